ap_com_lut_bank: RTL and testbench

- Parametrised bank of NUM_COMP approximate-compressor cells for the approximate Wallace multiplier reduction tree.
- Each cell is an IN_W-input, 1-output truth table that is programmable at run time, not fixed at elaboration. One bank therefore covers every compressor variant the evolutionary search produces.
- Cells are evaluated in a valid/ready pipeline of PIPE stages.
- Truth tables are written into a shadow copy and swapped into the active copy atomically, only after the pipeline has drained.

---
 rtl/ap_com_pkg.sv | 26 ++
 rtl/ap_com_lut_cell.sv | 42 ++++
 rtl/ap_com_lut_bank.sv | 127 ++++++++++++
 tb/tb_ap_com_lut_bank.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ap_com_pkg.sv
// Shared types and helpers for the approximate-compressor LUT bank.
package ap_com_pkg;

  // Widest supported cell; tables narrower than this use the low bits.
  localparam int IN_W_MAX = 4;
  localparam int TT_W     = 2 ** IN_W_MAX;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } bank_state_e;

  // Exact sum-bit table (XOR of all inputs) for an in_w-input cell.
  function automatic logic [TT_W-1:0] parity_tt(input int in_w);
    logic [TT_W-1:0] r;
    logic [IN_W_MAX-1:0] p;
    r = '0;
    for (int j = 0; j < TT_W; j++) begin
      p = j[IN_W_MAX-1:0];
      if (j < (1 << in_w)) r[j] = ^p;
    end
    return r;
  endfunction

endpackage

// File: rtl/ap_com_lut_cell.sv
// One programmable compressor cell: shadow + active truth table and lookup mux.
import ap_com_pkg::*;

module ap_com_lut_cell #(
  parameter int IN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [(1<<IN_W)-1:0]   tt,
  input  logic                   swap,
  input  logic [IN_W-1:0]        sel,
  output logic                   y
);

  localparam int TBL_W = 1 << IN_W;
  localparam logic [TT_W-1:0]  PAR_FULL = parity_tt(IN_W);
  localparam logic [TBL_W-1:0] PAR_TT   = PAR_FULL[TBL_W-1:0];

  logic [TBL_W-1:0] shadow_q, shadow_d;
  logic [TBL_W-1:0] active_q, active_d;

  // Writes land in the shadow; swap copies the whole shadow in one edge.
  always_comb begin
    shadow_d = wr_en ? tt : shadow_q;
    active_d = swap ? shadow_q : active_q;
  end

  // Table registers, both restored to the exact parity table on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= PAR_TT;
      active_q <= PAR_TT;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign y = active_q[sel];

endmodule

// File: rtl/ap_com_lut_bank.sv
// Bank of programmable compressor LUTs with a valid/ready evaluation
// pipeline and drain-then-swap table reconfiguration.
import ap_com_pkg::*;

module ap_com_lut_bank #(
  parameter int NUM_COMP = 33,
  parameter int IN_W     = 4,
  parameter int PIPE     = 1,
  parameter int EPOCH_W  = 8
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            cfg_valid,
  output logic                                            cfg_ready,
  input  logic [((NUM_COMP > 1) ? $clog2(NUM_COMP) : 1)-1:0] cfg_idx,
  input  logic [(1<<IN_W)-1:0]                            cfg_tt,
  input  logic                                            cfg_commit,
  output logic                                            cfg_err,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [NUM_COMP*IN_W-1:0]                        in_data,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [NUM_COMP-1:0]                             out_data,
  output logic [EPOCH_W-1:0]                              tt_epoch
);

  bank_state_e state_q, state_d;
  logic [PIPE-1:0]               vld_pipe_q, vld_pipe_d;
  logic [PIPE-1:0][NUM_COMP-1:0] data_pipe_q, data_pipe_d;
  logic [PIPE-1:0]               ld;
  logic [NUM_COMP-1:0]           cell_wr, cell_y;
  logic [EPOCH_W-1:0]            tt_epoch_q, tt_epoch_d;
  logic                          cfg_err_q, cfg_err_d;
  logic                          in_fire, cfg_fire, idx_oob, swap;

  // Stage s may load if the sink takes data or any stage at/after s is empty;
  // written from flop state only so there is no combinational chain on ld.
  always_comb begin
    for (int s = 0; s < PIPE; s++) begin
      ld[s] = out_ready;
      for (int t = s; t < PIPE; t++)
        if (!vld_pipe_q[t]) ld[s] = 1'b1;
    end
  end

  // Handshakes and per-cell shadow write enables.
  always_comb begin
    in_ready  = (state_q == RUN) && ld[0];
    cfg_ready = (state_q == RUN);
    in_fire   = in_valid && in_ready;
    cfg_fire  = cfg_valid && cfg_ready;
    idx_oob   = 32'(cfg_idx) >= 32'(NUM_COMP);
    cfg_err_d = cfg_fire && idx_oob;
    for (int k = 0; k < NUM_COMP; k++)
      cell_wr[k] = cfg_fire && !idx_oob && (32'(cfg_idx) == k);
  end

  // Pipeline advance: load on ld, hold otherwise; stage 0 captures the lookup.
  always_comb begin
    vld_pipe_d  = vld_pipe_q;
    data_pipe_d = data_pipe_q;
    if (ld[0]) begin
      vld_pipe_d[0] = in_fire;
      if (in_fire) data_pipe_d[0] = cell_y;
    end
    for (int s = 1; s < PIPE; s++) begin
      if (ld[s]) begin
        vld_pipe_d[s] = vld_pipe_q[s-1];
        if (vld_pipe_q[s-1]) data_pipe_d[s] = data_pipe_q[s-1];
      end
    end
  end

  // RUN -> DRAIN on commit; leave DRAIN in the same cycle the last beat
  // is taken so SWAP follows immediately; SWAP lasts one cycle.
  always_comb begin
    state_d    = state_q;
    swap       = 1'b0;
    tt_epoch_d = tt_epoch_q;
    case (state_q)
      RUN:   if (cfg_fire && cfg_commit) state_d = DRAIN;
      DRAIN: if (vld_pipe_d == '0) state_d = SWAP;
      SWAP: begin
        swap       = 1'b1;
        tt_epoch_d = tt_epoch_q + EPOCH_W'(1);
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Control and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      vld_pipe_q  <= '0;
      data_pipe_q <= '0;
      tt_epoch_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vld_pipe_q  <= vld_pipe_d;
      data_pipe_q <= data_pipe_d;
      tt_epoch_q  <= tt_epoch_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  for (genvar k = 0; k < NUM_COMP; k++) begin : g_cell
    ap_com_lut_cell #(.IN_W(IN_W)) u_cell (
      .clk   (clk),
      .rst   (rst),
      .wr_en (cell_wr[k]),
      .tt    (cfg_tt),
      .swap  (swap),
      .sel   (in_data[k*IN_W +: IN_W]),
      .y     (cell_y[k])
    );
  end

  assign out_valid = vld_pipe_q[PIPE-1];
  assign out_data  = data_pipe_q[PIPE-1];
  assign tt_epoch  = tt_epoch_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_ap_com_lut_bank.sv
// Directed + random bench for ap_com_lut_bank with a table-level reference model.
module tb_ap_com_lut_bank;

  localparam int NC = 33;
  localparam int IW = 4;
  localparam int P  = 2;
  localparam int EW = 8;
  localparam int XW = 6;

  logic clk = 1'b0;
  logic rst;
  logic cfg_valid, cfg_ready, cfg_commit, cfg_err;
  logic [XW-1:0] cfg_idx;
  logic [15:0] cfg_tt;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [NC*IW-1:0] in_data;
  logic [NC-1:0] out_data;
  logic [EW-1:0] tt_epoch;

  always #5 clk = ~clk;

  ap_com_lut_bank #(.NUM_COMP(NC), .IN_W(IW), .PIPE(P), .EPOCH_W(EW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_tt(cfg_tt), .cfg_commit(cfg_commit), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tt_epoch(tt_epoch)
  );

  // Reference model: active/shadow tables, epoch, expected results in order.
  logic [15:0]   m_act [NC];
  logic [15:0]   m_shd [NC];
  logic [EW-1:0] m_epoch;
  bit            m_pend, m_err_exp;
  logic [NC-1:0] sbq[$];
  int total = 0, bad = 0, n_in = 0, n_out = 0;

  bit last_fire, last_in_fire, last_in_ready, last_cfg_ready;
  logic [NC-1:0] last_out;
  logic [EW-1:0] last_epoch;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin m_act[k] = 16'h6996; m_shd[k] = 16'h6996; end
    m_epoch = '0; m_pend = 0; m_err_exp = 0;
    sbq.delete();
  endtask

  function automatic logic [NC-1:0] model_eval(input logic [NC*IW-1:0] d);
    logic [NC-1:0] r;
    logic [3:0] nib;
    for (int k = 0; k < NC; k++) begin
      nib  = d[k*IW +: IW];
      r[k] = m_act[k][nib];
    end
    return r;
  endfunction

  function automatic logic [NC*IW-1:0] rnd_data();
    logic [NC*IW-1:0] d;
    for (int k = 0; k < NC; k++) d[k*IW +: IW] = 4'($urandom_range(0, 15));
    return d;
  endfunction

  function automatic logic [NC*IW-1:0] fill(input logic [3:0] v);
    logic [NC*IW-1:0] d;
    for (int k = 0; k < NC; k++) d[k*IW +: IW] = v;
    return d;
  endfunction

  // One clock: sample at negedge, score, update model, return after posedge.
  task automatic cycle();
    logic [NC-1:0] e;
    @(negedge clk);
    chk("cfg_err", {63'd0, cfg_err}, {63'd0, m_err_exp});
    m_err_exp      = 0;
    last_fire      = out_valid && out_ready;
    last_in_fire   = in_valid && in_ready;
    last_in_ready  = in_ready;
    last_cfg_ready = cfg_ready;
    last_out       = out_data;
    last_epoch     = tt_epoch;
    if (last_fire) begin
      n_out++;
      if (sbq.size() == 0) chk("spurious_out", {63'd0, out_valid}, 64'd0);
      else begin e = sbq.pop_front(); chk("out_data", 64'(out_data), 64'(e)); end
    end else if (sbq.size() == 0) chk("idle_valid", {63'd0, out_valid}, 64'd0);
    if (last_in_fire) begin sbq.push_back(model_eval(in_data)); n_in++; end
    if (cfg_valid && cfg_ready) begin
      if (int'(cfg_idx) < NC) m_shd[cfg_idx] = cfg_tt; else m_err_exp = 1;
      if (cfg_commit) m_pend = 1;
    end
    if (m_pend && sbq.size() == 0) begin
      for (int k = 0; k < NC; k++) m_act[k] = m_shd[k];
      m_epoch++; m_pend = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic flush();
    in_valid = 0; cfg_valid = 0; out_ready = 1;
    for (int i = 0; i < 50 && sbq.size() > 0; i++) cycle();
    chk("flush_empty", 64'(sbq.size()), 64'd0);
  endtask

  task automatic rand_beats(input int n);
    out_ready = 1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1; in_data = rnd_data(); cycle();
    end
    flush();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc;
    rst = 1; cfg_valid = 0; cfg_idx = '0; cfg_tt = '0; cfg_commit = 0;
    in_valid = 0; in_data = '0; out_ready = 1;
    model_reset();
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_cfg_err", {63'd0, cfg_err}, 64'd0);
    chk("rst_epoch", 64'(tt_epoch), 64'd0);
    rst = 0;
    cycle();
    chk("rel_in_ready", {63'd0, last_in_ready}, 64'd1);
    chk("rel_cfg_ready", {63'd0, last_cfg_ready}, 64'd1);

    // Parity tables: 0011 -> 0, latency PIPE; 0001 -> all ones.
    in_valid = 1; in_data = fill(4'b0011); cycle(); in_valid = 0;
    n = 0;
    do begin cycle(); n++; end while (!last_fire && n < 20);
    chk("latency", 64'(n), 64'(P));
    chk("par_0011", 64'(last_out), 64'd0);
    in_valid = 1; in_data = fill(4'b0001); cycle(); in_valid = 0;
    n = 0;
    do begin cycle(); n++; end while (!last_fire && n < 20);
    chk("par_0001", 64'(last_out), 64'({NC{1'b1}}));

    // Program cell 0, commit with empty pipeline: in_ready low 2 cycles.
    cfg_valid = 1; cfg_idx = 0; cfg_tt = 16'h6404; cfg_commit = 0; cycle();
    cfg_commit = 1; cycle();
    cfg_valid = 0; cfg_commit = 0;
    cycle(); chk("swap_rdy0", {63'd0, last_in_ready}, 64'd0);
    cycle(); chk("swap_rdy1", {63'd0, last_in_ready}, 64'd0);
    cycle(); chk("swap_rdy2", {63'd0, last_in_ready}, 64'd1);
    chk("epoch_1", 64'(last_epoch), 64'd1);
    in_valid = 1; in_data = fill(4'b1101); cycle(); in_valid = 0;
    n = 0;
    do begin cycle(); n++; end while (!last_fire && n < 20);
    chk("tt6404_1101", 64'(last_out), 64'({NC{1'b1}}));
    rand_beats(20);

    // Commit with one beat stalled downstream: old table must be used.
    out_ready = 0;
    in_valid = 1; in_data = rnd_data(); cycle(); in_valid = 0;
    cfg_valid = 1; cfg_idx = 0; cfg_tt = ~m_shd[0]; cfg_commit = 1; cycle();
    cfg_valid = 0; cfg_commit = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("drain_in_ready", {63'd0, last_in_ready}, 64'd0);
      chk("drain_cfg_ready", {63'd0, last_cfg_ready}, 64'd0);
      chk("drain_epoch", 64'(last_epoch), 64'd1);
    end
    out_ready = 1;
    cycle(); chk("drain_take", {63'd0, last_fire}, 64'd1);
    chk("drain_take_rdy", {63'd0, last_in_ready}, 64'd0);
    cycle(); chk("swap_cycle_rdy", {63'd0, last_in_ready}, 64'd0);
    cycle(); chk("post_swap_rdy", {63'd0, last_in_ready}, 64'd1);
    chk("epoch_2", 64'(last_epoch), 64'(m_epoch));
    rand_beats(20);

    // Out-of-range index: error pulse, shadow untouched across a commit.
    cfg_valid = 1; cfg_idx = 6'd40; cfg_tt = 16'($urandom); cfg_commit = 0; cycle();
    cfg_valid = 0; cycle();
    chk("oob_err_hi", {63'd0, cfg_err}, 64'd0);
    cycle();
    cfg_valid = 1; cfg_idx = 6'd40; cfg_commit = 1; cycle();
    cfg_valid = 0; cfg_commit = 0;
    repeat (4) cycle();
    chk("epoch_3", 64'(last_epoch), 64'(m_epoch));
    rand_beats(20);

    // Random back-pressure, 1000 beats, order and count via scoreboard.
    n_in = 0; n_out = 0; acc = 0;
    for (int c = 0; c < 20000 && acc < 1000; c++) begin
      in_valid = 1'($urandom_range(0, 1)); in_data = rnd_data();
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      if (last_in_fire) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'd1000);
    flush();
    chk("bp_count", 64'(n_out), 64'(n_in));

    // Reset during DRAIN with two beats in flight.
    out_ready = 0;
    in_valid = 1; in_data = rnd_data(); cycle();
    in_data = rnd_data(); cycle(); in_valid = 0;
    cfg_valid = 1; cfg_idx = 3; cfg_tt = ~m_shd[3]; cfg_commit = 1; cycle();
    cfg_valid = 0; cfg_commit = 0;
    cycle(); chk("rstdrain_rdy", {63'd0, last_in_ready}, 64'd0);
    rst = 1; #1;
    chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_epoch", 64'(tt_epoch), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 0; out_ready = 1;
    cycle(); chk("rst_rel_rdy", {63'd0, last_in_ready}, 64'd1);
    in_valid = 1; in_data = fill(4'b0011); cycle(); in_valid = 0;
    n = 0;
    do begin cycle(); n++; end while (!last_fire && n < 20);
    chk("rst_par_0011", 64'(last_out), 64'd0);
    rand_beats(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
